// File: rtl/datapath2_if.sv
// datapath2_if: control, manual-bus and observation signals of the datapath2 CPU datapath.
// The control unit (or bench) drives through the master modport.
// The datapath itself connects through the slave modport.
interface datapath2_if;
    // bus-drive enables
    logic        PCout;
    logic        Zlowout;
    logic        Zhighout;
    logic        MDRout;
    logic        MBIout;
    logic        Cout;
    logic        Rout;
    logic        BAout;
    // register load enables
    logic        PCin;
    logic        IRin;
    logic        MARin;
    logic        MDRin;
    logic        Yin;
    logic        Zin;
    logic        Rin;
    logic        CONin;
    logic        OutportIn;
    // register-field selects
    logic        Gra;
    logic        Grb;
    logic        Grc;
    // memory control
    logic        Read;
    logic        Write;
    // ALU operation and manual bus value
    logic [4:0]  OpCode;
    logic [31:0] manualBusInput;
    // observation
    logic [31:0] outport_data;
    logic        con_out;
    logic [31:0] bus_out;

    modport master (
        output PCout, Zlowout, Zhighout, MDRout, MBIout, Cout, Rout, BAout,
        output PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin, OutportIn,
        output Gra, Grb, Grc, Read, Write, OpCode, manualBusInput,
        input  outport_data, con_out, bus_out
    );

    modport slave (
        input  PCout, Zlowout, Zhighout, MDRout, MBIout, Cout, Rout, BAout,
        input  PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin, OutportIn,
        input  Gra, Grb, Grc, Read, Write, OpCode, manualBusInput,
        output outport_data, con_out, bus_out
    );
endinterface

// File: rtl/datapath2.sv
// datapath2: single-bus 32-bit RISC datapath.
// Contents:
//   - 16x32 register file with select/encode
//   - PC, IR, MAR, MDR, Y and a 64-bit Z
//   - 512x32 RAM, ALU, CON flip-flop and output port
// Optional macro DATAPATH2_MULDIV_EN builds the signed multiplier and divider
// (OpCodes 9 and 10). Without it, those opcodes give Z = 0.
module datapath2 #(
    parameter int MEM_DEPTH = 512,
    parameter int REG_COUNT = 16
) (
    input  logic       clk,
    input  logic       clr,
    datapath2_if.slave dp
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mar;
    logic [31:0] mdr;
    logic [31:0] y;
    logic [63:0] z;
    logic [31:0] outport;
    logic        con;
    logic [31:0] regs [REG_COUNT];
    logic [31:0] ram  [MEM_DEPTH];

    logic [31:0] bus;
    logic [31:0] c_value;
    logic [31:0] sel_value;
    logic [31:0] ba_value;
    logic [31:0] mdr_d;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic [3:0]  sel;
    logic [1:0]  cond;
    logic [AW-1:0] addr;
    logic [63:0] alu_z;
    logic [63:0] rot;
    logic        con_d;

    // IR fields; the opcode bits are decoded by the external control unit
    assign ra      = ir[26:23];
    assign rb      = ir[22:19];
    assign rc      = ir[18:15];
    assign cond    = ir[20:19];
    assign c_value = {{13{ir[18]}}, ir[18:0]};

    // Select/encode: the enabled fields are OR-ed into one register index
    assign sel       = ({4{dp.Gra}} & ra) | ({4{dp.Grb}} & rb) | ({4{dp.Grc}} & rc);
    assign sel_value = regs[sel];
    assign ba_value  = (sel == 4'd0) ? 32'd0 : sel_value;

    // Upper MAR bits do not take part in addressing; the address wraps modulo MEM_DEPTH
    assign addr = mar[AW-1:0];

    logic unused_bits;
    assign unused_bits = &{1'b0, mar[31:AW], ir[31:27]};

    // Bus source mux, fixed priority when more than one driver is enabled
    always_comb begin
        bus = 32'd0;
        if (dp.MBIout)        bus = dp.manualBusInput;
        else if (dp.PCout)    bus = pc;
        else if (dp.MDRout)   bus = mdr;
        else if (dp.Zlowout)  bus = z[31:0];
        else if (dp.Zhighout) bus = z[63:32];
        else if (dp.Cout)     bus = c_value;
        else if (dp.Rout)     bus = sel_value;
        else if (dp.BAout)    bus = ba_value;
    end

    // MDR input mux and RAM write data. A write in the same cycle as an MDR load
    // stores the value that MDR is about to take.
    assign mem_rdata = ram[addr];
    assign mdr_d     = dp.Read ? mem_rdata : bus;
    assign mem_wdata = dp.MDRin ? mdr_d : mdr;

`ifdef DATAPATH2_MULDIV_EN
    logic [63:0] product;
    logic [31:0] div_b;
    logic [31:0] quotient;
    logic [31:0] remainder;

    // div_b is never zero, so the divider output stays defined when B is zero
    assign product   = $unsigned($signed({{32{y[31]}}, y}) * $signed({{32{bus[31]}}, bus}));
    assign div_b     = (bus == 32'd0) ? 32'd1 : bus;
    assign quotient  = $unsigned($signed(y) / $signed(div_b));
    assign remainder = $unsigned($signed(y) % $signed(div_b));
`endif

    // ALU: A = Y, B = bus. Every result except MUL and DIV leaves the high word zero
    always_comb begin
        alu_z = 64'd0;
        rot   = {y, y};
        case (dp.OpCode)
            5'd0:  alu_z[31:0] = y & bus;
            5'd1:  alu_z[31:0] = y | bus;
            5'd2:  alu_z[31:0] = y + bus;
            5'd3:  alu_z[31:0] = y - bus;
            5'd4:  alu_z[31:0] = y >> bus[4:0];
            5'd5:  alu_z[31:0] = $signed(y) >>> bus[4:0];
            5'd6:  alu_z[31:0] = y << bus[4:0];
            5'd7: begin
                rot         = {y, y} >> bus[4:0];
                alu_z[31:0] = rot[31:0];
            end
            5'd8: begin
                rot         = {y, y} << bus[4:0];
                alu_z[31:0] = rot[63:32];
            end
`ifdef DATAPATH2_MULDIV_EN
            5'd9:  alu_z = product;
            5'd10: alu_z = (bus == 32'd0) ? 64'd0 : {remainder, quotient};
`endif
            5'd11: alu_z[31:0] = 32'd0 - bus;
            5'd12: alu_z[31:0] = bus + 32'd1;
            5'd13: alu_z[31:0] = ~bus;
            5'd14: alu_z[31:0] = bus;
            default: alu_z = 64'd0;
        endcase
    end

    // Branch condition evaluated on the selected register (Ra via Gra)
    always_comb begin
        con_d = 1'b0;
        case (cond)
            2'b00: con_d = (sel_value == 32'd0);
            2'b01: con_d = (sel_value != 32'd0);
            2'b10: con_d = ~sel_value[31];
            2'b11: con_d = sel_value[31];
            default: con_d = 1'b0;
        endcase
    end

    // Special-purpose registers, each loading on its own enable
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc      <= 32'd0;
            ir      <= 32'd0;
            mar     <= 32'd0;
            mdr     <= 32'd0;
            y       <= 32'd0;
            z       <= 64'd0;
            outport <= 32'd0;
            con     <= 1'b0;
        end else begin
            if (dp.PCin)      pc      <= bus;
            if (dp.IRin)      ir      <= bus;
            if (dp.MARin)     mar     <= bus;
            if (dp.MDRin)     mdr     <= mdr_d;
            if (dp.Yin)       y       <= bus;
            if (dp.Zin)       z       <= alu_z;
            if (dp.OutportIn) outport <= bus;
            if (dp.CONin)     con     <= con_d;
        end
    end

    // General register file, written through the select/encode index
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= 32'd0;
        end else if (dp.Rin) begin
            regs[sel] <= bus;
        end
    end

    // Internal RAM: synchronous write, combinational read, contents survive reset
    always_ff @(posedge clk) begin
        if (dp.Write) ram[addr] <= mem_wdata;
    end

    assign dp.outport_data = outport;
    assign dp.con_out      = con;
    assign dp.bus_out      = bus;
endmodule

// File: tb/tb_datapath2.sv
// tb_datapath2: directed and randomized checks of the datapath2 datapath, observed through the bus.
module tb_datapath2;
    logic clk = 1'b0;
    logic clr = 1'b0;
    int   checks = 0;
    int   errors = 0;

    localparam int P_PC = 0, P_ZLO = 1, P_ZHI = 2, P_MDR = 3, P_C = 4, P_RA = 5, P_RB = 6, P_BAB = 7, P_IDLE = 8;

    datapath2_if dp ();
    datapath2 dut (.clk(clk), .clr(clr), .dp(dp));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clear_ctl();
        dp.PCout = 0; dp.Zlowout = 0; dp.Zhighout = 0; dp.MDRout = 0; dp.MBIout = 0;
        dp.Cout = 0; dp.Rout = 0; dp.BAout = 0;
        dp.PCin = 0; dp.IRin = 0; dp.MARin = 0; dp.MDRin = 0; dp.Yin = 0; dp.Zin = 0;
        dp.Rin = 0; dp.CONin = 0; dp.OutportIn = 0;
        dp.Gra = 0; dp.Grb = 0; dp.Grc = 0; dp.Read = 0; dp.Write = 0;
        dp.OpCode = 5'd0; dp.manualBusInput = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_ctl();
    endtask

    task automatic peek(input int src, output logic [31:0] v);
        case (src)
            P_PC:    dp.PCout = 1;
            P_ZLO:   dp.Zlowout = 1;
            P_ZHI:   dp.Zhighout = 1;
            P_MDR:   dp.MDRout = 1;
            P_C:     dp.Cout = 1;
            P_RA:    begin dp.Gra = 1; dp.Rout = 1; end
            P_RB:    begin dp.Grb = 1; dp.Rout = 1; end
            P_BAB:   begin dp.Grb = 1; dp.BAout = 1; end
            default: ;
        endcase
        @(negedge clk);
        v = dp.bus_out;
        clear_ctl();
    endtask

    task automatic mbi(input logic [31:0] v);
        dp.MBIout = 1;
        dp.manualBusInput = v;
    endtask

    task automatic load_ir(input logic [31:0] v);  mbi(v); dp.IRin = 1;  tick(); endtask
    task automatic load_y(input logic [31:0] v);   mbi(v); dp.Yin = 1;   tick(); endtask
    task automatic load_mar(input logic [31:0] v); mbi(v); dp.MARin = 1; tick(); endtask
    task automatic load_mdr(input logic [31:0] v); mbi(v); dp.MDRin = 1; tick(); endtask
    task automatic set_reg_a(input logic [31:0] v); mbi(v); dp.Gra = 1; dp.Rin = 1; tick(); endtask

    task automatic mem_write(input logic [31:0] a, input logic [31:0] v);
        load_mar(a);
        mbi(v); dp.MDRin = 1; dp.Write = 1; tick();
    endtask

    task automatic mem_read(input logic [31:0] a, output logic [31:0] v);
        load_mar(a);
        dp.Read = 1; dp.MDRin = 1; tick();
        peek(P_MDR, v);
    endtask

    task automatic alu_run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        load_y(a);
        mbi(b); dp.OpCode = op; dp.Zin = 1; tick();
    endtask

    // Reference ALU written from the operation definitions with integer arithmetic
    function automatic logic [63:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, t;
        int sh;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        p = 1;
        for (int k = 0; k < sh; k++) p = p * 2;
        r = 32'd0;
        case (op)
            0:  r = a & b;
            1:  r = a | b;
            2:  r = 32'(longint'(a) + longint'(b));
            3:  r = 32'(longint'(a) - longint'(b));
            4:  r = 32'(longint'(a) / p);
            5: begin
                t = sa / p;
                if (sa < 0 && (sa % p) != 0) t = t - 1;
                r = 32'(t);
            end
            6:  r = 32'(longint'(a) * p);
            7:  for (int i = 0; i < 32; i++) r[i] = a[(i + sh) % 32];
            8:  for (int i = 0; i < 32; i++) r[i] = a[(i + 32 - sh) % 32];
`ifdef DATAPATH2_MULDIV_EN
            9:  return 64'(sa * sb);
            10: begin
                if (b == 32'd0) return 64'd0;
                return {32'(sa % sb), 32'(sa / sb)};
            end
`endif
            11: r = 32'(longint'(0) - longint'(b));
            12: r = 32'(longint'(b) + 1);
            13: r = ~b;
            14: r = b;
            default: r = 32'd0;
        endcase
        return {32'd0, r};
    endfunction

    function automatic logic ref_con(input logic [1:0] c, input logic [31:0] v);
        int s;
        s = $signed(v);
        case (c)
            2'b00:   return s == 0;
            2'b01:   return s != 0;
            2'b10:   return s >= 0;
            default: return s < 0;
        endcase
    endfunction

    initial begin
        logic [31:0] v;
        logic [63:0] e;
        logic [31:0] a, b, val, irw;
        logic [3:0]  rsel;
        logic [1:0]  cnd;
        int          op;

        clear_ctl();
        clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        peek(P_PC, v);   check("reset_pc", v, 32'd0);
        peek(P_ZLO, v);  check("reset_zlo", v, 32'd0);
        peek(P_ZHI, v);  check("reset_zhi", v, 32'd0);
        check("reset_con", {31'd0, dp.con_out}, 32'd0);
        check("reset_outport", dp.outport_data, 32'd0);
        peek(P_IDLE, v); check("idle_bus", v, 32'd0);
        clr = 1'b1;
        repeat (2) tick();
        peek(P_PC, v);   check("hold_pc", v, 32'd0);
        check("hold_outport", dp.outport_data, 32'd0);

        // asynchronous clear between clock edges
        mbi(32'h55); dp.PCin = 1; tick();
        peek(P_PC, v); check("pc_load", v, 32'h55);
        #2 clr = 1'b0;
        #1 dp.PCout = 1;
        #1 check("async_clr_pc", dp.bus_out, 32'd0);
        clear_ctl();
        clr = 1'b1;
        tick();

        // fetch
        mbi(32'd0); dp.PCin = 1; dp.MARin = 1; tick();
        mbi(32'h12000090); dp.MDRin = 1; dp.Write = 1; tick();
        dp.PCout = 1; dp.MARin = 1; dp.OpCode = 5'd12; dp.Zin = 1; tick();
        peek(P_ZLO, v); check("t0_z", v, 32'd1);
        dp.Zlowout = 1; dp.PCin = 1; tick();
        dp.Read = 1; dp.MDRin = 1; tick();
        peek(P_PC, v);  check("t1_pc", v, 32'd1);
        peek(P_MDR, v); check("t1_mdr", v, 32'h12000090);
        dp.MDRout = 1; dp.IRin = 1; tick();
        peek(P_C, v);   check("t2_ir_c", v, 32'h90);

        // store R4, 144(R0)
        mbi(32'h777); dp.Grb = 1; dp.Rin = 1; tick();
        set_reg_a(32'd0);
        mem_write(32'd144, 32'hDEADBEEF);
        peek(P_RB, v);  check("r0_rout", v, 32'h777);
        dp.Grb = 1; dp.BAout = 1; dp.Yin = 1;
        @(negedge clk);
        check("t3_baout_r0", dp.bus_out, 32'd0);
        tick();
        dp.Cout = 1; dp.OpCode = 5'd2; dp.Zin = 1; tick();
        peek(P_ZLO, v); check("t4_zlo", v, 32'd144);
        peek(P_ZHI, v); check("t4_zhi", v, 32'd0);
        dp.Zlowout = 1; dp.MARin = 1; tick();
        dp.Gra = 1; dp.Rout = 1; dp.MDRin = 1; dp.Write = 1; tick();
        mbi(32'h1234); dp.MDRin = 1; tick();
        dp.Read = 1; dp.MDRin = 1; tick();
        peek(P_MDR, v); check("t6_ram144", v, 32'd0);
        mem_read(32'd0, v); check("ram0_kept", v, 32'h12000090);

        // write from the held MDR value, and address wrap
        load_mdr(32'hABCD1234);
        load_mar(32'd33);
        dp.Write = 1; tick();
        mem_read(32'd33, v); check("write_held_mdr", v, 32'hABCD1234);
        load_mar(32'h20A);
        load_mdr(32'd9);
        dp.Write = 1; tick();
        mem_read(32'd10, v); check("mem_wrap", v, 32'd9);

        // CON
        load_ir((32'd3 << 23) | (32'd2 << 19));
        set_reg_a(32'hFFFFFFFF);
        dp.Gra = 1; dp.CONin = 1; tick();
        check("con_neg_ge", {31'd0, dp.con_out}, 32'd0);
        set_reg_a(32'd5);
        dp.Gra = 1; dp.CONin = 1; tick();
        check("con_pos_ge", {31'd0, dp.con_out}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            rsel = 4'($urandom_range(0, 15));
            cnd  = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       val = 32'd0;
                1:       val = ($urandom & 32'h7FFFFFFF) | 32'd1;
                2:       val = $urandom | 32'h80000000;
                default: val = $urandom;
            endcase
            irw = ({28'd0, rsel} << 23) | ({30'd0, cnd} << 19);
            load_ir(irw);
            set_reg_a(val);
            peek(P_RA, v); check("reg_rand", v, val);
            dp.Gra = 1; dp.CONin = 1; tick();
            check("con_rand", {31'd0, dp.con_out}, {31'd0, ref_con(cnd, val)});
        end

        // output port
        mbi(32'hCAFEF00D); dp.OutportIn = 1; tick();
        check("outport", dp.outport_data, 32'hCAFEF00D);

        // bus priority
        mbi(32'h11); dp.PCin = 1; tick();
        load_mdr(32'h22);
        mbi(32'h33); dp.PCout = 1;
        @(negedge clk); check("prio_mbi_pc", dp.bus_out, 32'h33); clear_ctl();
        dp.PCout = 1; dp.MDRout = 1;
        @(negedge clk); check("prio_pc_mdr", dp.bus_out, 32'h11); clear_ctl();
        dp.MDRout = 1; dp.Zlowout = 1; dp.Cout = 1;
        @(negedge clk); check("prio_mdr_z", dp.bus_out, 32'h22); clear_ctl();

        // ALU directed
        alu_run(5'd9, 32'hFFFFFFFA, 32'd4);
        e = ref_alu(9, 32'hFFFFFFFA, 32'd4);
`ifdef DATAPATH2_MULDIV_EN
        check("mul_model_lo", e[31:0], 32'hFFFFFFE8);
`endif
        peek(P_ZLO, v); check("mul_lo", v, e[31:0]);
        peek(P_ZHI, v); check("mul_hi", v, e[63:32]);
        alu_run(5'd10, 32'hFFFFFFFA, 32'd4);
        e = ref_alu(10, 32'hFFFFFFFA, 32'd4);
        peek(P_ZLO, v); check("div_quo", v, e[31:0]);
        peek(P_ZHI, v); check("div_rem", v, e[63:32]);
        alu_run(5'd10, 32'hFFFFFFFA, 32'd0);
        peek(P_ZLO, v); check("div0_lo", v, 32'd0);
        peek(P_ZHI, v); check("div0_hi", v, 32'd0);
        alu_run(5'd5, 32'h80000000, 32'd4);
        peek(P_ZLO, v); check("shra", v, 32'hF8000000);

        // ALU randomized against the reference
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 31);
            a  = $urandom;
            b  = $urandom;
            if (op == 10 && $urandom_range(0, 7) == 0) b = 32'd0;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            alu_run(5'(op), a, b);
            e = ref_alu(op, a, b);
            peek(P_ZLO, v); check($sformatf("alu_lo op%0d", op), v, e[31:0]);
            peek(P_ZHI, v); check($sformatf("alu_hi op%0d", op), v, e[63:32]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
